// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder.
//   state_t    : padder FSM states
//   blk_t      : one 512-bit block as 16 big-endian 32-bit words, word 0 first
//   PAD_BYTE   : end-of-message marker byte
//   BLK_BYTES  : bytes per block
//   LEN_OFFSET : byte position of the 64-bit length field inside a block
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, FILL, PAD, EXTRA, EMIT} state_t;

    typedef logic [0:15][31:0] blk_t;

    localparam logic [7:0] PAD_BYTE   = 8'h80;
    localparam int         BLK_BYTES  = 64;
    localparam int         LEN_OFFSET = 56;

endpackage

// File: rtl/sha256_pad_insert.sv
// sha256_pad_insert: combinational padding of one block.
//   buffer    in  : block holding the message bytes
//   n         in  : number of valid message bytes in buffer (0..64)
//   length    in  : message length in bits, zero-extended to 64 bits
//   marker_en in  : place 0x80 at byte n (ignored when n = 64)
//   padded    out : bytes < n from buffer, optional marker at n, zeros after,
//                   length at bytes 56..63 when the data leaves room (n < 56)
module sha256_pad_insert
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  blk_t             buffer,
    input  logic [6:0]       n,
    input  logic [LEN_W-1:0] length,
    input  logic             marker_en,
    output blk_t             padded
);

    logic [63:0] len64;
    assign len64 = 64'(length);

    for (genvar k = 0; k < BLK_BYTES; k++) begin : g_byte
        logic [7:0] data_b;
        assign data_b = (7'(k) < n) ? buffer[k/4][31-8*(k%4) -: 8] :
                        ((7'(k) == n) && marker_en) ? PAD_BYTE : 8'h00;
        if (k >= LEN_OFFSET) begin : g_len
            // Length field only fits when the marker lands before byte 56.
            assign padded[k/4][31-8*(k%4) -: 8] =
                (n < 7'(LEN_OFFSET)) ? len64[8*(63-k) +: 8] : data_b;
        end else begin : g_dat
            assign padded[k/4][31-8*(k%4) -: 8] = data_b;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: byte-stream to padded 512-bit block converter for SHA-256.
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid/in_byte/in_last/in_ready : message byte stream (in_last marks final byte)
//   blk_valid/blk_data/blk_last/blk_ready : padded block output, word 0 first
//   busy                    : a message is in progress
//   blk_count               : blocks handshaken since reset (SHA256_PAD_BLKCNT_EN only)
// Optional feature macro: SHA256_PAD_BLKCNT_EN.
// Zero-length messages cannot be expressed (in_last needs a byte to ride on).
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W     = 64,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 blk_valid,
    output blk_t                 blk_data,
    output logic                 blk_last,
    input  logic                 blk_ready,
`ifdef SHA256_PAD_BLKCNT_EN
    output logic [BLK_CNT_W-1:0] blk_count,
`endif
    output logic                 busy
);

    state_t           state;
    blk_t             buf_q, buf_wr, pad_blk, pad_src;
    logic [6:0]       idx, pad_n, pad_ins_n;
    logic [LEN_W-1:0] len;
    logic             extra_pend;   // a length-only block still has to follow
    logic             extra_mark;   // that block starts with the 0x80 marker
    logic             pad_mark_en;
    logic [4:0]       lane_sh;

    // Buffer with the incoming byte merged at the current index.
    always_comb begin
        buf_wr  = buf_q;
        lane_sh = {~idx[1:0], 3'b000};
        buf_wr[idx[5:2]][lane_sh +: 8] = in_byte;
    end

    // EXTRA pads an empty buffer; PAD pads the collected data.
    assign pad_src     = (state == EXTRA) ? '0 : buf_q;
    assign pad_ins_n   = (state == EXTRA) ? 7'd0 : pad_n;
    assign pad_mark_en = (state == EXTRA) ? extra_mark : 1'b1;

    sha256_pad_insert #(.LEN_W(LEN_W)) u_pad (
        .buffer    (pad_src),
        .n         (pad_ins_n),
        .length    (len),
        .marker_en (pad_mark_en),
        .padded    (pad_blk)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            buf_q      <= '0;
            idx        <= '0;
            pad_n      <= '0;
            len        <= '0;
            extra_pend <= 1'b0;
            extra_mark <= 1'b0;
            in_ready   <= 1'b0;
            blk_valid  <= 1'b0;
            blk_data   <= '0;
            blk_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
                FILL: if (in_valid) begin
                    buf_q <= buf_wr;
                    idx   <= idx + 7'd1;
                    len   <= len + LEN_W'(8);
                    busy  <= 1'b1;
                    if (in_last) begin
                        state    <= PAD;
                        in_ready <= 1'b0;
                        pad_n    <= idx + 7'd1;
                    end else if (idx == 7'(BLK_BYTES - 1)) begin
                        state      <= EMIT;
                        in_ready   <= 1'b0;
                        blk_valid  <= 1'b1;
                        blk_last   <= 1'b0;
                        blk_data   <= buf_wr;
                        extra_pend <= 1'b0;
                    end
                end
                PAD: begin
                    state      <= EMIT;
                    blk_data   <= pad_blk;
                    blk_valid  <= 1'b1;
                    blk_last   <= (pad_n < 7'(LEN_OFFSET));
                    extra_pend <= (pad_n >= 7'(LEN_OFFSET));
                    extra_mark <= (pad_n == 7'(BLK_BYTES));
                end
                EXTRA: begin
                    state      <= EMIT;
                    blk_data   <= pad_blk;
                    blk_valid  <= 1'b1;
                    blk_last   <= 1'b1;
                    extra_pend <= 1'b0;
                end
                EMIT: if (blk_ready) begin
                    blk_valid <= 1'b0;
                    if (extra_pend) begin
                        state <= EXTRA;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        buf_q    <= '0;
                        idx      <= '0;
                        if (blk_last) begin
                            len  <= '0;
                            busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA256_PAD_BLKCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blk_count <= '0;
        else if (blk_valid && blk_ready)
            blk_count <= blk_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  in_byte;
    logic        blk_valid, blk_last, blk_ready, busy;
    blk_t        blk_data;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_count;
`endif

    sha256_msg_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .blk_ready (blk_ready),
`ifdef SHA256_PAD_BLKCNT_EN
        .blk_count (blk_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { blk_t d; logic l; } exp_t;

    int         vec = 0, err = 0;
    int         cyc = 0;
    int         rdy_mode = 0;        // 0: always ready, 1: random, 2: stalled
    int         exp_lat = 0, drv_cyc = 0;
    int         hs_cnt = 0;
    logic [7:0] msg_q[$];
    exp_t       exp_q[$];
    exp_t       cap_q[$];
    logic       prev_valid = 1'b0, held = 1'b0, hold_l;
    blk_t       hold_d;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       blk_ready = 1'b1;
            1:       blk_ready = 1'($urandom_range(0, 1));
            default: blk_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vec++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t got, input blk_t want);
        vec++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Reference padding: append 0x80, zero until 56 mod 64, append 64-bit bit length.
    function automatic void model_push();
        logic [7:0]  p[$];
        logic [63:0] bits;
        exp_t        e;
        int          nb;
        p    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 16; w++)
                e.d[w] = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
            e.l = (b == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Output monitor: every handshake is scored; stalls must hold the block.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
            held       = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(blk_valid), 64'd1);
                chk_blk("hold_data", blk_data, hold_d);
                chk("hold_last", 64'(blk_last), 64'(hold_l));
            end
            if (blk_valid) chk("in_ready_while_valid", 64'(in_ready), 64'd0);
            if (blk_valid && !prev_valid && exp_lat != 0) begin
                chk("latency", 64'(cyc - drv_cyc), 64'(exp_lat));
                exp_lat = 0;
            end
            if (blk_valid && blk_ready) begin
                chk("busy_at_handshake", 64'(busy), 64'd1);
`ifdef SHA256_PAD_BLKCNT_EN
                chk("blk_count", 64'(blk_count), 64'(hs_cnt[15:0]));
`endif
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    vec++; err++;
                    $display("FAIL unexpected_block: got %h expected none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_blk("blk_data", blk_data, e.d);
                    chk("blk_last", 64'(blk_last), 64'(e.l));
                end
                e.d = blk_data; e.l = blk_last;
                cap_q.push_back(e);
                held = 1'b0;
            end else if (blk_valid) begin
                held   = 1'b1;
                hold_d = blk_data;
                hold_l = blk_last;
            end else begin
                held = 1'b0;
            end
            prev_valid = blk_valid;
        end
    end

    task automatic send(input bit with_last, input bit gaps);
        int i = 0, g = 0;
        while (i < msg_q.size()) begin
            @(negedge clk);
            g++;
            if (g > 20000) begin
                vec++; err++;
                $display("FAIL send_timeout: got %0d bytes expected %0d", i, msg_q.size());
                break;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                in_last  = 1'($urandom);   // must be ignored without in_valid
            end else begin
                in_valid = 1'b1;
                in_byte  = msg_q[i];
                in_last  = with_last && (i == msg_q.size() - 1);
                if (in_ready) begin
                    if (in_last) begin exp_lat = 2; drv_cyc = cyc; end
                    else if (i % 64 == 63) begin exp_lat = 1; drv_cyc = cyc; end
                    i++;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || blk_valid) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            vec++; err++;
            $display("FAIL drain_timeout: got %0d blocks left expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic load_str(input string s);
        msg_q = {};
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic load_fill(input int n, input logic [7:0] b, input bit rnd);
        msg_q = {};
        for (int i = 0; i < n; i++) msg_q.push_back(rnd ? 8'($urandom) : b);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_blk_valid"}, 64'(blk_valid), 64'd0);
        chk({tag, "_blk_last"}, 64'(blk_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk_blk({tag, "_blk_data"}, blk_data, '0);
`ifdef SHA256_PAD_BLKCNT_EN
        chk({tag, "_blk_count"}, 64'(blk_count), 64'd0);
`endif
    endtask

    task automatic chk_hello(input string tag);
        if (cap_q.size() != 1) begin
            vec++; err++;
            $display("FAIL %s_count: got %0d blocks expected 1", tag, cap_q.size());
        end else begin
            chk({tag, "_w0"}, 64'(cap_q[0].d[0]), 64'h68656c6c);
            chk({tag, "_w1"}, 64'(cap_q[0].d[1]), 64'h6f20776f);
            chk({tag, "_w2"}, 64'(cap_q[0].d[2]), 64'h726c6480);
            chk({tag, "_w14"}, 64'(cap_q[0].d[14]), 64'h0);
            chk({tag, "_w15"}, 64'(cap_q[0].d[15]), 64'h58);
            chk({tag, "_last"}, 64'(cap_q[0].l), 64'd1);
        end
    endtask

    initial begin
        int lens[8] = '{55, 56, 63, 64, 65, 119, 120, 128};
        int cnt0;
        reset = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("reset");
        @(negedge clk) reset = 1'b0;

        // "hello world": model pinned against the hand-computed block first.
        load_str("hello world");
        model_push();
        chk("model_hello_w0", 64'(exp_q[0].d[0]), 64'h68656c6c);
        chk("model_hello_w15", 64'(exp_q[0].d[15]), 64'h58);
        cap_q = {};
        send(1, 0);
        wait_drain();
        chk_hello("hello");

        // 55 bytes: marker and length share one block.
        load_fill(55, 8'h61, 0); model_push(); cap_q = {};
        send(1, 0); wait_drain();
        if (cap_q.size() == 1) begin
            chk("a55_w13", 64'(cap_q[0].d[13]), 64'h61616180);
            chk("a55_w15", 64'(cap_q[0].d[15]), 64'h1b8);
            chk("a55_last", 64'(cap_q[0].l), 64'd1);
        end else chk("a55_count", 64'(cap_q.size()), 64'd1);

        // 56 bytes: marker fills block 1, length-only block 2.
        load_fill(56, 8'h61, 0); model_push(); cap_q = {};
        send(1, 0); wait_drain();
        if (cap_q.size() == 2) begin
            chk("a56_b0_w14", 64'(cap_q[0].d[14]), 64'h80000000);
            chk("a56_b0_w15", 64'(cap_q[0].d[15]), 64'h0);
            chk("a56_b0_last", 64'(cap_q[0].l), 64'd0);
            chk("a56_b1_w0", 64'(cap_q[1].d[0]), 64'h0);
            chk("a56_b1_w15", 64'(cap_q[1].d[15]), 64'h1c0);
            chk("a56_b1_last", 64'(cap_q[1].l), 64'd1);
        end else chk("a56_count", 64'(cap_q.size()), 64'd2);

        // 64 zero bytes: data block then marker+length block.
        load_fill(64, 8'h00, 0); model_push(); cap_q = {};
        send(1, 0); wait_drain();
        if (cap_q.size() == 2) begin
            chk_blk("z64_b0", cap_q[0].d, '0);
            chk("z64_b0_last", 64'(cap_q[0].l), 64'd0);
            chk("z64_b1_w0", 64'(cap_q[1].d[0]), 64'h80000000);
            chk("z64_b1_w15", 64'(cap_q[1].d[15]), 64'h200);
            chk("z64_b1_last", 64'(cap_q[1].l), 64'd1);
        end else chk("z64_count", 64'(cap_q.size()), 64'd2);

        // Backpressure: stall the block for 10 cycles.
        cnt0 = hs_cnt;
        rdy_mode = 2;
        load_fill(20, 8'h00, 1); model_push();
        send(1, 0);
        for (int g = 0; g < 50 && !blk_valid; g++) @(negedge clk);
        chk("bp_valid", 64'(blk_valid), 64'd1);
        repeat (10) @(negedge clk);
        rdy_mode = 0;
        wait_drain();
        chk("bp_one_handshake", 64'(hs_cnt - cnt0), 64'd1);
`ifdef SHA256_PAD_BLKCNT_EN
        chk("bp_blk_count", 64'(blk_count), 64'(hs_cnt));
`endif

        // Reset after 30 bytes of an unfinished message.
        load_fill(30, 8'h00, 1);
        send(0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_outs("midreset");
        chk("midreset_no_pending", 64'(exp_q.size()), 64'd0);
        hs_cnt = 0;
        @(negedge clk) reset = 1'b0;
        load_str("hello world"); model_push(); cap_q = {};
        send(1, 0); wait_drain();
        chk_hello("hello2");

        // Boundary lengths and random messages under random backpressure and gaps.
        rdy_mode = 1;
        foreach (lens[j]) begin
            load_fill(lens[j], 8'h00, 1); model_push();
            send(1, 1); wait_drain();
        end
        for (int m = 0; m < 25; m++) begin
            load_fill($urandom_range(1, 200), 8'h00, 1); model_push();
            send(1, 1); wait_drain();
        end
        rdy_mode = 0;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 co-processor: accepts a raw message as a byte stream.
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Emits 512-bit blocks as 16 x 32-bit words in the same word layout the co-processor's data_in expects.
- Handles multi-block messages and the extra length-only block; valid/ready on both sides.

Parameters:
- LEN_W, 64, width of the message bit-length counter; length field always 64 bits, zero-extended if LEN_W<64.
- BLK_CNT_W, 16, width of the optional block counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  message byte.
- in_last  in  1  final byte of message, qualified by in_valid.
- in_ready  out  1  padder accepts a byte this cycle.
- blk_valid  out  1  blk_data holds a complete padded block.
- blk_data  out  [0:15][31:0]  block words; word 0 first, big-endian bytes.
- blk_last  out  1  block is the final block of the message.
- blk_ready  in  1  downstream consumes block.
- busy  out  1  message in progress (FILL/PAD/EMIT/EXTRA).

Behaviour:
- Reset: state IDLE; buffer, byte index, length counter = 0; in_ready=0, blk_valid=0, blk_last=0, blk_data=0, busy=0. A reset mid-message discards partial data and does not emit a block.
- IDLE -> FILL on the cycle after reset deasserts. in_ready=1 in FILL only.
- Byte placement: byte k of a block goes to word k/4, bits [31-8*(k%4) -: 8]. Length counter += 8 per accepted byte, wrapping modulo 2^LEN_W.
- Block full without last (64th byte, in_last=0): FILL -> EMIT. blk_valid=1, blk_last=0 the next cycle.
- in_last accepted with n bytes in the current block (1..64): FILL -> PAD for exactly one cycle, in_ready=0.
  - n<=55: 0x80 at byte n, zeros to byte 55, length at bytes 56..63; EMIT with blk_last=1.
  - 56<=n<=63: 0x80 at byte n, zeros to byte 63; EMIT with blk_last=0, then EXTRA.
  - n=64: EMIT the data block with blk_last=0, then EXTRA. The EXTRA block has 0x80 at byte 0.
- EXTRA: builds all-zero block (plus 0x80 at byte 0 if n=64), length at bytes 56..63; EMIT with blk_last=1 the next cycle.
- EMIT: blk_data and blk_last held stable while blk_valid & !blk_ready. Handshake completes on blk_valid & blk_ready:
  - if more blocks pending -> EXTRA;
  - else buffer and index cleared -> FILL;
  - if the completed block had blk_last=1, the length counter is also cleared.
- Latency: data-only block valid 1 cycle after the 64th byte; final single block valid 2 cycles after last byte (PAD+EMIT); extra block valid 1 cycle after the previous handshake.
- Zero-length messages are not supported (no byte to carry in_last); documented limitation.
- in_last while in_valid=0 is ignored. in_ready never asserts in PAD/EMIT/EXTRA.

Optional Feature:
- Macro SHA256_PAD_BLKCNT_EN.
- Defined: adds output blk_count [BLK_CNT_W-1:0] = number of blocks handshaken since reset. Wraps at 2^BLK_CNT_W. Reset to 0. Increments on blk_valid & blk_ready.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package sha256_pkg: state enum (IDLE, FILL, PAD, EXTRA, EMIT), block typedef logic [0:15][31:0], constants PAD_BYTE=8'h80, BLK_BYTES=64, LEN_OFFSET=56.
- Sub-module sha256_pad_insert (combinational): inputs buffer, n, length, marker_en; outputs padded block. Shared by PAD and EXTRA.

Test Plan:
- "hello world" (11 bytes, in_last on 'd'), blk_ready=1 -> one block: 68656c6c 6f20776f 726c6480, words 3..14 = 0, word15 = 00000058, blk_last=1; valid 2 cycles after last byte.
- 55 bytes of 0x61 -> single block: byte 55=0x80, word15=000001B8, blk_last=1.
- 56 bytes of 0x61 -> block 1: byte 56=0x80, bytes 57..63=0, blk_last=0; block 2: words 0..14=0, word15=000001C0, blk_last=1.
- 64 bytes of 0x00 -> block 1: all data, blk_last=0; block 2: word0=80000000, word15=00000200, blk_last=1.
- Backpressure: blk_ready=0 for 10 cycles during EMIT -> blk_data/blk_last stable, in_ready=0; the next message starts only after the handshake; blk_count (SHA256_PAD_BLKCNT_EN) increments once.
- Reset asserted after 30 bytes -> outputs at reset values immediately; a new "hello world" afterwards yields the block of the first scenario (length not polluted).
